// File: rtl/exc_pkg.sv
// exc_pkg: shared state, cause and MOVRM index definitions for the exception controller.
package exc_pkg;
    typedef enum logic [1:0] {RUN, FLUSH, REDIRECT, HALT} state_e;
    localparam logic [2:0] CAUSE_NONE    = 3'd0;
    localparam logic [2:0] CAUSE_ITLB    = 3'd1;
    localparam logic [2:0] CAUSE_ILLEGAL = 3'd2;
    localparam logic [2:0] CAUSE_DTLB    = 3'd3;
    localparam logic [2:0] CAUSE_PRIV    = 3'd4;
    localparam logic [1:0] RM_EPC   = 2'd0;
    localparam logic [1:0] RM_CAUSE = 2'd1;
    localparam logic [1:0] RM_BADVA = 2'd2;
    localparam logic [1:0] RM_PRIV  = 2'd3;
endpackage

// File: rtl/exc_priority_encoder.sv
// exc_priority_encoder: picks the single highest-priority writeback event.
module exc_priority_encoder
    import exc_pkg::*;
(
    input  logic       valid,
    input  logic       itlb_miss,
    input  logic       panic,
    input  logic       dtlb_miss,
    input  logic       iret,
    input  logic       tlbwrite,
    input  logic       priv,
    output logic       take_exc,
    output logic       take_iret,
    output logic       do_tlbwrite,
    output logic [2:0] cause
);
    always_comb begin
        cause = !valid ? CAUSE_NONE :
                itlb_miss ? CAUSE_ITLB :
                panic ? CAUSE_ILLEGAL :
                dtlb_miss ? CAUSE_DTLB :
                ((iret || tlbwrite) && !priv) ? CAUSE_PRIV : CAUSE_NONE;
        take_exc    = cause != CAUSE_NONE;
        take_iret   = valid && !take_exc && iret;
        do_tlbwrite = valid && !take_exc && !iret && tlbwrite;
    end
endmodule

// File: rtl/exception_controller.sv
// exception_controller: privilege bit, rm0-rm2 and the flush/redirect sequencing
// for exception entry, IRET return and double-fault halt.
module exception_controller
    import exc_pkg::*;
#(
    parameter int               XLEN         = 32,
    parameter logic [XLEN-1:0]  HANDLER_PC   = 'h0000_2000,
    parameter int               FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wb_valid,
    input  logic [XLEN-1:0] wb_pc,
    input  logic            wb_panic,
    input  logic            wb_iret,
    input  logic            wb_tlbwrite,
    input  logic            wb_itlb_miss,
    input  logic            wb_dtlb_miss,
    input  logic [XLEN-1:0] wb_fault_va,
    input  logic [1:0]      rm_sel,
    output logic [XLEN-1:0] rm_rdata,
    output logic            priv,
    output logic            tlbwrite_en,
    output logic            flush,
    output logic            stall,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            halted
);
    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            priv_q, priv_d;
    logic [XLEN-1:0] rm0_q, rm0_d, rm1_q, rm1_d, rm2_q, rm2_d, rpc_q, rpc_d;
    logic            take_exc, take_iret, do_tlbwrite;
    logic [2:0]      cause;

    exc_priority_encoder u_enc (
        .valid      (state_q == RUN && wb_valid),
        .itlb_miss  (wb_itlb_miss),
        .panic      (wb_panic),
        .dtlb_miss  (wb_dtlb_miss),
        .iret       (wb_iret),
        .tlbwrite   (wb_tlbwrite),
        .priv       (priv_q),
        .take_exc   (take_exc),
        .take_iret  (take_iret),
        .do_tlbwrite(do_tlbwrite),
        .cause      (cause)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        priv_d  = priv_q;
        rm0_d   = rm0_q;
        rm1_d   = rm1_q;
        rm2_d   = rm2_q;
        rpc_d   = rpc_q;
        unique case (state_q)
            RUN: begin
                if (take_exc) begin
                    rm0_d  = wb_pc;
                    rm1_d  = XLEN'(cause);
                    rm2_d  = (cause == CAUSE_ITLB || cause == CAUSE_DTLB) ? wb_fault_va : '0;
                    priv_d = 1'b1;
                    rpc_d  = HANDLER_PC;
                    cnt_d  = CW'(FLUSH_CYCLES);
                    if (priv_q) state_d = HALT;
                    else        state_d = FLUSH;
                end else if (take_iret) begin
                    priv_d  = 1'b0;
                    rpc_d   = rm0_q + XLEN'(4);
                    cnt_d   = CW'(FLUSH_CYCLES);
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (cnt_q == CW'(1)) state_d = REDIRECT;
                else                 cnt_d = cnt_q - CW'(1);
            end
            REDIRECT: state_d = RUN;
            default:  state_d = HALT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            priv_q  <= 1'b1;
            rm0_q   <= '0;
            rm1_q   <= '0;
            rm2_q   <= '0;
            rpc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            priv_q  <= priv_d;
            rm0_q   <= rm0_d;
            rm1_q   <= rm1_d;
            rm2_q   <= rm2_d;
            rpc_q   <= rpc_d;
        end
    end

    assign priv           = priv_q;
    assign tlbwrite_en    = do_tlbwrite;
    assign flush          = state_q == FLUSH || state_q == HALT;
    assign stall          = state_q != RUN;
    assign redirect_valid = state_q == REDIRECT;
    assign redirect_pc    = rpc_q;
    assign halted         = state_q == HALT;
    assign rm_rdata = rm_sel == RM_EPC   ? rm0_q :
                      rm_sel == RM_CAUSE ? rm1_q :
                      rm_sel == RM_BADVA ? rm2_q : {{(XLEN-1){1'b0}}, priv_q};
endmodule

// File: tb/tb_exception_controller.sv
// tb_exception_controller: directed scenarios plus randomized run against a cycle-count reference model.
module tb_exception_controller;
    localparam int FC = 2;
    localparam logic [31:0] HPC = 32'h0000_2000;

    logic        clk = 0, rst_n = 0;
    logic        wb_valid = 0, wb_panic = 0, wb_iret = 0, wb_tlbwrite = 0, wb_itlb_miss = 0, wb_dtlb_miss = 0;
    logic [31:0] wb_pc = 0, wb_fault_va = 0, rm_rdata, redirect_pc;
    logic [1:0]  rm_sel = 0;
    logic        priv, tlbwrite_en, flush, stall, redirect_valid, halted;
    int          errors = 0, checks = 0;

    // reference model: phase counts cycles since the accepted event, 0 = running
    logic        m_priv, m_halt;
    logic [31:0] m_rm [3];
    logic [31:0] m_rpc;
    int          m_phase;

    exception_controller #(.XLEN(32), .HANDLER_PC(HPC), .FLUSH_CYCLES(FC)) dut (
        .clk(clk), .rst_n(rst_n), .wb_valid(wb_valid), .wb_pc(wb_pc), .wb_panic(wb_panic),
        .wb_iret(wb_iret), .wb_tlbwrite(wb_tlbwrite), .wb_itlb_miss(wb_itlb_miss),
        .wb_dtlb_miss(wb_dtlb_miss), .wb_fault_va(wb_fault_va), .rm_sel(rm_sel),
        .rm_rdata(rm_rdata), .priv(priv), .tlbwrite_en(tlbwrite_en), .flush(flush),
        .stall(stall), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic cyc(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_wb();
        wb_valid = 0; wb_panic = 0; wb_iret = 0; wb_tlbwrite = 0;
        wb_itlb_miss = 0; wb_dtlb_miss = 0; wb_pc = 0; wb_fault_va = 0;
    endtask

    task automatic read_rm(input logic [1:0] sel, output logic [31:0] v);
        rm_sel = sel;
        #1;
        v = rm_rdata;
    endtask

    task automatic do_reset();
        rst_n = 0;
        clear_wb();
        cyc(2);
        rst_n = 1;
        m_priv = 1; m_halt = 0; m_phase = 0; m_rpc = 0;
        foreach (m_rm[i]) m_rm[i] = 0;
    endtask

    // supervisor IRET, then wait until running again in user mode
    task automatic to_user();
        wb_valid = 1; wb_iret = 1;
        cyc();
        clear_wb();
        cyc(FC + 1);
    endtask

    task automatic test_reset();
        logic [31:0] v;
        rst_n = 0;
        #1;
        checks++; if ({flush, stall, redirect_valid, tlbwrite_en, halted} !== 5'b0) begin errors++; $display("FAIL reset_outs got %b exp 00000", {flush, stall, redirect_valid, tlbwrite_en, halted}); end
        checks++; if (redirect_pc !== 32'h0) begin errors++; $display("FAIL reset_rpc got %h exp 0", redirect_pc); end
        do_reset();
        checks++; if (priv !== 1'b1) begin errors++; $display("FAIL reset_priv got %b exp 1", priv); end
        for (int s = 0; s < 3; s++) begin
            read_rm(2'(s), v);
            checks++; if (v !== 32'h0) begin errors++; $display("FAIL reset_rm%0d got %h exp 0", s, v); end
        end
        read_rm(2'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL reset_rm3 got %h exp 1", v); end
    endtask

    task automatic test_panic_user();
        logic [31:0] v;
        do_reset();
        to_user();
        checks++; if (priv !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL user_entry got priv=%b stall=%b exp 0 0", priv, stall); end
        wb_valid = 1; wb_panic = 1; wb_pc = 32'h100;
        read_rm(2'd0, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL pre_update_rm0 got %h exp 0", v); end
        cyc();
        clear_wb();
        read_rm(2'd0, v);
        checks++; if (v !== 32'h100) begin errors++; $display("FAIL panic_rm0 got %h exp 100", v); end
        read_rm(2'd1, v);
        checks++; if (v !== 32'h2) begin errors++; $display("FAIL panic_rm1 got %h exp 2", v); end
        read_rm(2'd2, v);
        checks++; if (v !== 32'h0) begin errors++; $display("FAIL panic_rm2 got %h exp 0", v); end
        checks++; if (priv !== 1'b1 || flush !== 1'b1 || redirect_valid !== 1'b0) begin errors++; $display("FAIL panic_t1 got priv=%b flush=%b rv=%b exp 1 1 0", priv, flush, redirect_valid); end
        cyc();
        checks++; if (flush !== 1'b1 || stall !== 1'b1) begin errors++; $display("FAIL panic_t2 got flush=%b stall=%b exp 1 1", flush, stall); end
        cyc();
        checks++; if (flush !== 1'b0 || redirect_valid !== 1'b1 || redirect_pc !== HPC || stall !== 1'b1) begin errors++; $display("FAIL panic_t3 got flush=%b rv=%b pc=%h stall=%b exp 0 1 %h 1", flush, redirect_valid, redirect_pc, stall, HPC); end
        cyc();
        checks++; if (redirect_valid !== 1'b0 || stall !== 1'b0) begin errors++; $display("FAIL panic_t4 got rv=%b stall=%b exp 0 0", redirect_valid, stall); end
    endtask

    task automatic test_itlb_dtlb();
        logic [31:0] v;
        do_reset();
        to_user();
        wb_valid = 1; wb_itlb_miss = 1; wb_dtlb_miss = 1; wb_fault_va = 32'hDEAD_0000; wb_pc = 32'h300;
        cyc();
        clear_wb();
        read_rm(2'd1, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL tlb_rm1 got %h exp 1", v); end
        read_rm(2'd2, v);
        checks++; if (v !== 32'hDEAD_0000) begin errors++; $display("FAIL tlb_rm2 got %h exp dead0000", v); end
        cyc(FC + 1);
    endtask

    task automatic test_iret();
        logic [31:0] v;
        do_reset();
        to_user();
        wb_valid = 1; wb_panic = 1; wb_pc = 32'h1FC;
        cyc();
        clear_wb();
        cyc(FC + 1);
        wb_valid = 1; wb_iret = 1;
        cyc();
        clear_wb();
        checks++; if (priv !== 1'b0 || flush !== 1'b1) begin errors++; $display("FAIL iret_t1 got priv=%b flush=%b exp 0 1", priv, flush); end
        wb_valid = 1; wb_panic = 1; wb_pc = 32'h500;
        cyc();
        clear_wb();
        read_rm(2'd0, v);
        checks++; if (v !== 32'h1FC || priv !== 1'b0) begin errors++; $display("FAIL iret_drop got rm0=%h priv=%b exp 1fc 0", v, priv); end
        cyc();
        checks++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'h200) begin errors++; $display("FAIL iret_redirect got rv=%b pc=%h exp 1 200", redirect_valid, redirect_pc); end
        cyc();
        checks++; if (stall !== 1'b0 || priv !== 1'b0) begin errors++; $display("FAIL iret_resume got stall=%b priv=%b exp 0 0", stall, priv); end
    endtask

    task automatic test_tlbwrite();
        logic [31:0] v;
        do_reset();
        wb_valid = 1; wb_tlbwrite = 1;
        #1;
        checks++; if (tlbwrite_en !== 1'b1) begin errors++; $display("FAIL tlbw_sup got %b exp 1", tlbwrite_en); end
        cyc();
        clear_wb();
        #1;
        checks++; if (tlbwrite_en !== 1'b0 || flush !== 1'b0 || stall !== 1'b0 || priv !== 1'b1) begin errors++; $display("FAIL tlbw_sup_after got en=%b flush=%b stall=%b priv=%b exp 0 0 0 1", tlbwrite_en, flush, stall, priv); end
        wb_valid = 1; wb_tlbwrite = 1; wb_panic = 1;
        #1;
        checks++; if (tlbwrite_en !== 1'b0) begin errors++; $display("FAIL tlbw_masked got %b exp 0", tlbwrite_en); end
        do_reset();
        to_user();
        wb_valid = 1; wb_tlbwrite = 1;
        #1;
        checks++; if (tlbwrite_en !== 1'b0) begin errors++; $display("FAIL tlbw_user got %b exp 0", tlbwrite_en); end
        cyc();
        clear_wb();
        read_rm(2'd1, v);
        checks++; if (v !== 32'h4 || flush !== 1'b1 || priv !== 1'b1) begin errors++; $display("FAIL tlbw_priv got rm1=%h flush=%b priv=%b exp 4 1 1", v, flush, priv); end
        cyc(FC + 1);
    endtask

    task automatic test_double_fault();
        logic [31:0] v;
        do_reset();
        wb_valid = 1; wb_panic = 1; wb_pc = 32'h40;
        cyc();
        clear_wb();
        read_rm(2'd0, v);
        checks++; if (v !== 32'h40) begin errors++; $display("FAIL dbl_rm0 got %h exp 40", v); end
        for (int i = 0; i < 6; i++) begin
            checks++; if ({halted, stall, flush, redirect_valid} !== 4'b1110) begin errors++; $display("FAIL dbl_hold%0d got %b exp 1110", i, {halted, stall, flush, redirect_valid}); end
            cyc();
        end
        rst_n = 0;
        #1;
        read_rm(2'd1, v);
        checks++; if ({halted, stall, flush} !== 3'b0 || priv !== 1'b1 || v !== 32'h0) begin errors++; $display("FAIL dbl_reset got hsf=%b priv=%b rm1=%h exp 000 1 0", {halted, stall, flush}, priv, v); end
        do_reset();
        checks++; if (stall !== 1'b0 || priv !== 1'b1) begin errors++; $display("FAIL dbl_run got stall=%b priv=%b exp 0 1", stall, priv); end
    endtask

    task automatic test_reset_mid_flush();
        logic [31:0] v;
        int pulses = 0;
        do_reset();
        to_user();
        wb_valid = 1; wb_panic = 1; wb_pc = 32'h80;
        cyc();
        clear_wb();
        rst_n = 0;
        #1;
        checks++; if ({flush, stall, redirect_valid} !== 3'b0 || redirect_pc !== 32'h0) begin errors++; $display("FAIL midrst got fsr=%b pc=%h exp 000 0", {flush, stall, redirect_valid}, redirect_pc); end
        cyc();
        rst_n = 1;
        for (int i = 0; i < 6; i++) begin
            if (redirect_valid) pulses++;
            cyc();
        end
        checks++; if (pulses !== 0) begin errors++; $display("FAIL midrst_redirect got %0d pulses exp 0", pulses); end
        read_rm(2'd3, v);
        checks++; if (v !== 32'h1) begin errors++; $display("FAIL midrst_rm3 got %h exp 1", v); end
    endtask

    task automatic test_random();
        logic [31:0] v;
        logic [2:0]  c;
        logic        acc, e_tw;
        do_reset();
        for (int n = 0; n < 800; n++) begin
            checks++; if (flush !== (m_halt || (m_phase >= 1 && m_phase <= FC))) begin errors++; $display("FAIL rnd_flush@%0d got %b exp %b", n, flush, !flush); end
            checks++; if (stall !== (m_halt || m_phase >= 1)) begin errors++; $display("FAIL rnd_stall@%0d got %b exp %b", n, stall, !stall); end
            checks++; if (redirect_valid !== (!m_halt && m_phase == FC + 1)) begin errors++; $display("FAIL rnd_rv@%0d got %b exp %b", n, redirect_valid, !redirect_valid); end
            checks++; if (halted !== m_halt || priv !== m_priv) begin errors++; $display("FAIL rnd_hp@%0d got h=%b p=%b exp %b %b", n, halted, priv, m_halt, m_priv); end
            if (!m_halt && m_phase >= 1) begin
                checks++; if (redirect_pc !== m_rpc) begin errors++; $display("FAIL rnd_rpc@%0d got %h exp %h", n, redirect_pc, m_rpc); end
            end
            if (m_halt) begin
                do_reset();
                continue;
            end
            wb_valid = 1'($urandom % 2);
            wb_itlb_miss = ($urandom % 10) == 0;
            wb_panic = ($urandom % 12) == 0;
            wb_dtlb_miss = ($urandom % 10) == 0;
            wb_iret = ($urandom % 5) == 0;
            wb_tlbwrite = ($urandom % 4) == 0;
            wb_pc = $urandom & 32'hFFFF_FFFC;
            wb_fault_va = $urandom;
            read_rm(2'($urandom % 4), v);
            checks++; if (v !== (rm_sel == 2'd3 ? {31'h0, m_priv} : m_rm[rm_sel])) begin errors++; $display("FAIL rnd_rm%0d@%0d got %h", rm_sel, n, v); end
            acc = !m_halt && m_phase == 0 && wb_valid;
            c = wb_itlb_miss ? 3'd1 : wb_panic ? 3'd2 : wb_dtlb_miss ? 3'd3 : ((wb_iret || wb_tlbwrite) && !m_priv) ? 3'd4 : 3'd0;
            e_tw = acc && c == 0 && !wb_iret && wb_tlbwrite;
            checks++; if (tlbwrite_en !== e_tw) begin errors++; $display("FAIL rnd_tw@%0d got %b exp %b", n, tlbwrite_en, e_tw); end
            if (acc && c != 0) begin
                m_rm[0] = wb_pc;
                m_rm[1] = 32'(c);
                m_rm[2] = (c == 1 || c == 3) ? wb_fault_va : 32'h0;
                if (m_priv) m_halt = 1;
                else begin m_priv = 1; m_phase = 1; m_rpc = HPC; end
            end else if (acc && wb_iret) begin
                m_priv = 0; m_phase = 1; m_rpc = m_rm[0] + 32'd4;
            end else if (m_phase > 0) begin
                m_phase = (m_phase == FC + 1) ? 0 : m_phase + 1;
            end
            cyc();
        end
        clear_wb();
    endtask

    initial begin
        test_reset();
        test_panic_user();
        test_itlb_dtlb();
        test_iret();
        test_tlbwrite();
        test_double_fault();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
